// File: rtl/pong_pkg.sv
// Shared definitions for the pong split/merge pair: payload width and lane numbering.
package pong_pkg;

  localparam int unsigned PONG_WIDTH = 704;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_t;

  function automatic lane_t lane_flip(input lane_t l);
    return (l == LANE0) ? LANE1 : LANE0;
  endfunction

endpackage

// File: rtl/fifo_pong_split_if.sv
// Enqueue stream plus two dequeue lanes of the ping-pong splitter.
interface fifo_pong_split_if
  import pong_pkg::*;
#(
  parameter int unsigned WIDTH = PONG_WIDTH
);
  logic             in_enq__ENA;
  logic [WIDTH-1:0] in_enq_v;
  logic             in_enq__RDY;
  logic             out0_deq__ENA;
  logic             out0_deq__RDY;
  logic [WIDTH-1:0] out0_first;
  logic             out0_first__RDY;
  logic             out1_deq__ENA;
  logic             out1_deq__RDY;
  logic [WIDTH-1:0] out1_first;
  logic             out1_first__RDY;

  modport master (
    output in_enq__ENA, in_enq_v, out0_deq__ENA, out1_deq__ENA,
    input  in_enq__RDY, out0_deq__RDY, out0_first, out0_first__RDY,
           out1_deq__RDY, out1_first, out1_first__RDY
  );

  modport slave (
    input  in_enq__ENA, in_enq_v, out0_deq__ENA, out1_deq__ENA,
    output in_enq__RDY, out0_deq__RDY, out0_first, out0_first__RDY,
           out1_deq__RDY, out1_first, out1_first__RDY
  );
endinterface

// File: rtl/fifo_pong_lane.sv
// Single circular FIFO lane; RDYs depend on registered count only, no bypass.
module fifo_pong_lane
  import pong_pkg::*;
#(
  parameter int unsigned WIDTH = PONG_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enq_ena_i,
  input  logic [WIDTH-1:0] enq_v_i,
  output logic             enq_rdy_o,
  input  logic             deq_ena_i,
  output logic             deq_rdy_o,
  output logic [WIDTH-1:0] first_o
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             enq_fire, deq_fire;

  assign enq_rdy_o = (count_q != FULL);
  assign deq_rdy_o = (count_q != '0);
  assign first_o   = mem_q[rd_ptr_q];
  assign enq_fire  = enq_ena_i & enq_rdy_o;
  assign deq_fire  = deq_ena_i & deq_rdy_o;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (deq_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST && enq_fire) mem_q[wr_ptr_q] <= enq_v_i;
  end

endmodule

// File: rtl/fifo_pong_split.sv
// Ping-pong demultiplexer: accepted enqs alternate between lane0 and lane1 FIFOs.
module fifo_pong_split
  import pong_pkg::*;
#(
  parameter int unsigned WIDTH = PONG_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  fifo_pong_split_if.slave    bus
);
  lane_t wsel_q, wsel_d;
  logic  enq_rdy0, enq_rdy1;
  logic  deq_rdy0, deq_rdy1;
  logic  enq_fire;

  // Ordering is strict: only the selected lane's fullness gates input.
  assign bus.in_enq__RDY = (wsel_q == LANE1) ? enq_rdy1 : enq_rdy0;
  assign enq_fire        = bus.in_enq__ENA & bus.in_enq__RDY;

  always_comb begin
    wsel_d = wsel_q;
    if (enq_fire) wsel_d = lane_flip(wsel_q);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) wsel_q <= LANE0;
    else       wsel_q <= wsel_d;
  end

  fifo_pong_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .CLK       (CLK),
    .nRST      (nRST),
    .enq_ena_i (bus.in_enq__ENA & (wsel_q == LANE0)),
    .enq_v_i   (bus.in_enq_v),
    .enq_rdy_o (enq_rdy0),
    .deq_ena_i (bus.out0_deq__ENA),
    .deq_rdy_o (deq_rdy0),
    .first_o   (bus.out0_first)
  );

  fifo_pong_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .CLK       (CLK),
    .nRST      (nRST),
    .enq_ena_i (bus.in_enq__ENA & (wsel_q == LANE1)),
    .enq_v_i   (bus.in_enq_v),
    .enq_rdy_o (enq_rdy1),
    .deq_ena_i (bus.out1_deq__ENA),
    .deq_rdy_o (deq_rdy1),
    .first_o   (bus.out1_first)
  );

  assign bus.out0_deq__RDY   = deq_rdy0;
  assign bus.out0_first__RDY = deq_rdy0;
  assign bus.out1_deq__RDY   = deq_rdy1;
  assign bus.out1_first__RDY = deq_rdy1;

endmodule

// File: tb/tb_fifo_pong_split.sv
// Directed vector table plus scoreboarded random back-pressure run for fifo_pong_split.
module tb_fifo_pong_split;
  localparam int unsigned W     = 704;
  localparam int unsigned DEPTH = 2;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  fifo_pong_split_if #(.WIDTH(W)) bus ();

  fifo_pong_split #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    logic         rst_n, enq, d0, d1;
    logic [W-1:0] v;
    logic         erdy, r0, r1;
    logic [W-1:0] f0, f1;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [W-1:0] pat(input logic [7:0] b);
    return {88{b}};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic av(input logic rst_n, input logic enq, input logic [7:0] b,
                    input logic d0, input logic d1, input logic erdy,
                    input logic r0, input logic r1, input logic [7:0] f0, input logic [7:0] f1);
    vec_t t;
    t.rst_n = rst_n; t.enq = enq; t.v = pat(b); t.d0 = d0; t.d1 = d1;
    t.erdy = erdy; t.r0 = r0; t.r1 = r1; t.f0 = pat(f0); t.f1 = pat(f1);
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rst_n, input logic enq, input logic [W-1:0] v,
                       input logic d0, input logic d1);
    nRST              = rst_n;
    bus.in_enq__ENA   = enq;
    bus.in_enq_v      = v;
    bus.out0_deq__ENA = d0;
    bus.out1_deq__ENA = d1;
  endtask

  logic [W-1:0] q0[$], q1[$];
  logic         mw;
  logic         e_en, e_d0, e_d1, m_erdy;
  logic [W-1:0] e_v;
  int           drain;

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    //  rst enq  v     d0 d1  erdy r0 r1  f0    f1
    av(0, 1, 8'hFF, 1, 1,   1, 0, 0, 8'h00, 8'h00);
    av(0, 1, 8'hFF, 1, 1,   1, 0, 0, 8'h00, 8'h00);
    av(1, 1, 8'hA1, 0, 0,   1, 1, 0, 8'hA1, 8'h00);
    av(1, 1, 8'hA2, 0, 0,   1, 1, 1, 8'hA1, 8'hA2);
    av(1, 1, 8'hA3, 0, 0,   1, 1, 1, 8'hA1, 8'hA2);
    av(1, 1, 8'hA4, 0, 0,   0, 1, 1, 8'hA1, 8'hA2);
    av(1, 0, 8'h00, 1, 0,   1, 1, 1, 8'hA3, 8'hA2);
    av(1, 0, 8'h00, 0, 1,   1, 1, 1, 8'hA3, 8'hA4);
    av(1, 0, 8'h00, 1, 1,   1, 0, 0, 8'h00, 8'h00);
    av(1, 1, 8'hB1, 0, 0,   1, 1, 0, 8'hB1, 8'h00);
    av(1, 1, 8'hB2, 0, 0,   1, 1, 1, 8'hB1, 8'hB2);
    av(1, 1, 8'hB3, 0, 0,   1, 1, 1, 8'hB1, 8'hB2);
    av(1, 1, 8'hB4, 0, 0,   0, 1, 1, 8'hB1, 8'hB2);
    av(1, 1, 8'hB5, 0, 0,   0, 1, 1, 8'hB1, 8'hB2);
    av(1, 1, 8'hB6, 1, 0,   1, 1, 1, 8'hB3, 8'hB2);
    av(1, 1, 8'hB6, 0, 0,   0, 1, 1, 8'hB3, 8'hB2);
    av(1, 0, 8'h00, 1, 1,   1, 1, 1, 8'hB6, 8'hB4);
    av(1, 0, 8'h00, 0, 1,   1, 1, 0, 8'hB6, 8'h00);
    av(1, 1, 8'hC1, 0, 0,   1, 1, 1, 8'hB6, 8'hC1);
    av(1, 1, 8'hC2, 1, 0,   1, 1, 1, 8'hC2, 8'hC1);
    av(1, 0, 8'h00, 1, 1,   1, 0, 0, 8'h00, 8'h00);
    av(1, 0, 8'h00, 1, 1,   1, 0, 0, 8'h00, 8'h00);
    av(1, 1, 8'hD1, 0, 0,   1, 0, 1, 8'h00, 8'hD1);
    av(1, 0, 8'h00, 0, 1,   1, 0, 0, 8'h00, 8'h00);
    av(1, 1, 8'hE1, 0, 0,   1, 1, 0, 8'hE1, 8'h00);
    av(0, 1, 8'hEE, 0, 0,   1, 0, 0, 8'h00, 8'h00);
    av(1, 1, 8'hE2, 0, 0,   1, 1, 0, 8'hE2, 8'h00);
    av(1, 0, 8'h00, 1, 0,   1, 0, 0, 8'h00, 8'h00);

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].rst_n, vecs[i].enq, vecs[i].v, vecs[i].d0, vecs[i].d1);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_enq_rdy", i), W'(bus.in_enq__RDY), W'(vecs[i].erdy));
      chk($sformatf("v%0d_rdy0", i), W'(bus.out0_deq__RDY), W'(vecs[i].r0));
      chk($sformatf("v%0d_rdy1", i), W'(bus.out1_deq__RDY), W'(vecs[i].r1));
      chk($sformatf("v%0d_frdy0", i), W'(bus.out0_first__RDY), W'(vecs[i].r0));
      chk($sformatf("v%0d_frdy1", i), W'(bus.out1_first__RDY), W'(vecs[i].r1));
      if (vecs[i].r0) chk($sformatf("v%0d_first0", i), bus.out0_first, vecs[i].f0);
      if (vecs[i].r1) chk($sformatf("v%0d_first1", i), bus.out1_first, vecs[i].f1);
    end

    // Random back-pressure run against a queue scoreboard, starting from reset.
    @(negedge CLK);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge CLK);
    mw = 1'b0;
    drain = 0;
    for (int k = 0; k < 400; k++) begin
      if (k < 300) begin
        e_en = ($urandom_range(0, 3) != 0);
        e_d0 = ($urandom_range(0, 2) != 0);
        e_d1 = ($urandom_range(0, 2) != 0);
      end else begin
        e_en = 1'b0; e_d0 = 1'b1; e_d1 = 1'b1;
        drain++;
      end
      e_v = {W'(k) << 640} | W'({$urandom(), $urandom()});
      drive(1'b1, e_en, e_v, e_d0, e_d1);
      #1;
      m_erdy = mw ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
      chk($sformatf("r%0d_enq_rdy", k), W'(bus.in_enq__RDY), W'(m_erdy));
      chk($sformatf("r%0d_rdy0", k), W'(bus.out0_deq__RDY), W'(q0.size() != 0));
      chk($sformatf("r%0d_rdy1", k), W'(bus.out1_deq__RDY), W'(q1.size() != 0));
      if (q0.size() != 0) chk($sformatf("r%0d_first0", k), bus.out0_first, q0[0]);
      if (q1.size() != 0) chk($sformatf("r%0d_first1", k), bus.out1_first, q1[0]);
      @(posedge CLK);
      if (e_d0 && q0.size() != 0) void'(q0.pop_front());
      if (e_d1 && q1.size() != 0) void'(q1.pop_front());
      if (e_en && m_erdy) begin
        if (mw) q1.push_back(e_v);
        else    q0.push_back(e_v);
        mw = ~mw;
      end
      @(negedge CLK);
      if (k >= 300 && q0.size() == 0 && q1.size() == 0) break;
    end
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("drain_rdy0", W'(bus.out0_deq__RDY), W'(1'b0));
    chk("drain_rdy1", W'(bus.out1_deq__RDY), W'(1'b0));
    chk("drain_bound", W'(drain <= 10), W'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
